// File: rtl/pdm_frame_sequencer.sv
// Bit-clock divider, frame strobes and power sequencing for the PDM mic -> CIC -> I2S amp path.
// One shared bit clock feeds the mic (pdm_clk) and the amp (BCLK); PCM and amp stay gated until the CIC has settled.
module pdm_frame_sequencer #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned FRAME_BITS    = 64,
  parameter int unsigned WAKE_FRAMES   = 16,
  parameter int unsigned SETTLE_FRAMES = 4,
  localparam int unsigned BIT_W        = $clog2(FRAME_BITS)
) (
  input  logic             clk_25m,
  input  logic             rst,
  input  logic             enable,
  input  logic             mute,
  output logic             pdm_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [BIT_W-1:0] bit_idx,
  output logic             lrclk,
  output logic             frame_tick,
  output logic             cic_clr,
  output logic             pcm_en,
  output logic             pcm_mute,
  output logic             amp_sd,
  output logic [1:0]       state
);

  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAX_FRAMES = (WAKE_FRAMES > SETTLE_FRAMES) ? WAKE_FRAMES : SETTLE_FRAMES;
  localparam int unsigned FCNT_W     = $clog2(MAX_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(FRAME_BITS - 1);
  localparam logic [FCNT_W-1:0] WAKE_LAST   = FCNT_W'(WAKE_FRAMES - 1);
  localparam logic [FCNT_W-1:0] SETTLE_LAST = FCNT_W'(SETTLE_FRAMES - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX    = FCNT_W'(MAX_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t             cur_state;
  state_t             nxt_state;
  logic [DIV_W-1:0]   div_cnt;
  logic [FCNT_W-1:0]  frame_cnt;
  logic               div_wrap_c;
  logic               bit_wrap_c;
  logic               hold_c;

  // A divider wrap while pdm_clk is high is a falling edge; on the last bit it closes the frame.
  assign div_wrap_c = (cur_state != IDLE) && (div_cnt == DIV_LAST);
  assign bit_wrap_c = div_wrap_c && pdm_clk && (bit_idx == BIT_LAST);

  // Clock path parked at zero while idle or when WAKE/SETTLE is abandoned; a RUN stop lands on a frame edge.
  assign hold_c = (cur_state == IDLE) || ((nxt_state == IDLE) && (cur_state != RUN));

  assign lrclk = bit_idx[BIT_W-1];
  assign state = cur_state;

  always_ff @(posedge clk_25m) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      IDLE:    if (enable) nxt_state = WAKE;
      WAKE: begin
        if (!enable)                                     nxt_state = IDLE;
        else if (frame_tick && (frame_cnt == WAKE_LAST)) nxt_state = SETTLE;
      end
      SETTLE: begin
        if (!enable)                                       nxt_state = IDLE;
        else if (frame_tick && (frame_cnt == SETTLE_LAST)) nxt_state = RUN;
      end
      RUN:     if (!enable && bit_wrap_c) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      div_cnt    <= '0;
      pdm_clk    <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      frame_tick <= 1'b0;
      bit_idx    <= '0;
      frame_cnt  <= '0;
      cic_clr    <= 1'b1;
      pcm_en     <= 1'b0;
      pcm_mute   <= 1'b1;
      amp_sd     <= 1'b0;
    end else begin
      if (hold_c) begin
        div_cnt    <= '0;
        pdm_clk    <= 1'b0;
        rise_tick  <= 1'b0;
        fall_tick  <= 1'b0;
        frame_tick <= 1'b0;
        bit_idx    <= '0;
      end else begin
        rise_tick  <= div_wrap_c && !pdm_clk;
        fall_tick  <= div_wrap_c && pdm_clk;
        frame_tick <= bit_wrap_c;
        if (div_wrap_c) begin
          div_cnt <= '0;
          pdm_clk <= !pdm_clk;
          if (pdm_clk) bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      // Frames seen in the current state; restarts on every state change and saturates.
      if (nxt_state != cur_state)                  frame_cnt <= '0;
      else if (frame_tick && frame_cnt != FCNT_MAX) frame_cnt <= frame_cnt + 1'b1;

      cic_clr <= (nxt_state == IDLE) || (nxt_state == WAKE);
      pcm_en  <= (nxt_state == RUN);
      amp_sd  <= (nxt_state == RUN);

      // Mute is only taken at a frame boundary so a frame is never half muted.
      if (nxt_state != RUN)                    pcm_mute <= 1'b1;
      else if (cur_state == RUN && bit_wrap_c) pcm_mute <= mute;
    end
  end

endmodule
